// File: rtl/crossbar_shadow.sv
// crossbar_shadow: routes SoC event inputs to PMU counter outputs.
// Config is staged in a shadow bank and committed atomically.
module crossbar_shadow #(
   parameter int N_IN  = 32,
   parameter int N_OUT = 24,
   localparam int SW = $clog2(N_IN),
   localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IN-1:0]  vector_i,
   input  logic             cfg_we_i,
   input  logic [IW-1:0]    cfg_idx_i,
   input  logic [SW-1:0]    cfg_sel_i,
   input  logic [1:0]       cfg_mode_i,
   input  logic             cfg_commit_i,
   output logic [N_OUT-1:0] vector_o,
   output logic             cfg_pending_o,
   output logic             cfg_err_o
);

   typedef enum logic [1:0] {
      M_OFF  = 2'b00,
      M_LVL  = 2'b01,
      M_RISE = 2'b10,
      M_FALL = 2'b11
   } mode_e;

   typedef struct packed {
      logic [SW-1:0] sel;
      mode_e         mode;
   } cfg_t;

   cfg_t             shadow_q [N_OUT];
   cfg_t             shadow_d [N_OUT];
   cfg_t             active_q [N_OUT];
   cfg_t             active_d [N_OUT];
   logic [N_IN-1:0]  in_q, in_qq;
   logic [N_OUT-1:0] vec_q, vec_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;
   logic             idx_ok, sel_ok, wr_ok;

   assign idx_ok = int'(cfg_idx_i) < N_OUT;
   assign sel_ok = int'(cfg_sel_i) < N_IN;
   assign wr_ok  = cfg_we_i & idx_ok & sel_ok;

   // Config banks: the write lands in shadow and bypasses into a same-cycle commit.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_ok) begin
         shadow_d[cfg_idx_i].sel  = cfg_sel_i;
         shadow_d[cfg_idx_i].mode = mode_e'(cfg_mode_i);
      end
      if (cfg_commit_i) begin
         active_d = shadow_d;
      end
      pend_d = cfg_commit_i ? 1'b0 : (pend_q | wr_ok);
      err_d  = cfg_we_i & ~(idx_ok & sel_ok);
   end

   // Output stage: sel and mode come from the same active entry, so no mixing.
   always_comb begin
      vec_d = '0;
      for (int x = 0; x < N_OUT; x++) begin
         unique case (active_q[x].mode)
            M_OFF:  vec_d[x] = 1'b0;
            M_LVL:  vec_d[x] = in_q[active_q[x].sel];
            M_RISE: vec_d[x] = in_q[active_q[x].sel]
                             & ~in_qq[active_q[x].sel];
            M_FALL: vec_d[x] = ~in_q[active_q[x].sel]
                             & in_qq[active_q[x].sel];
         endcase
      end
   end

   // State registers; reset clears everything without waiting for a clock.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int x = 0; x < N_OUT; x++) begin
            shadow_q[x] <= '{sel: '0, mode: M_OFF};
            active_q[x] <= '{sel: '0, mode: M_OFF};
         end
         in_q   <= '0;
         in_qq  <= '0;
         vec_q  <= '0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         in_q     <= vector_i;
         in_qq    <= in_q;
         vec_q    <= vec_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
      end
   end

   assign vector_o      = vec_q;
   assign cfg_pending_o = pend_q;
   assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_crossbar_shadow.sv
// tb_crossbar_shadow: randomized and directed checks of the crossbar
// against a cycle-level reference model of the routing rules.
module tb_crossbar_shadow;

   localparam int N_IN  = 24;
   localparam int N_OUT = 24;
   localparam int SW = $clog2(N_IN);
   localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_IN-1:0]  vin = '0;
   logic             we = 1'b0;
   logic [IW-1:0]    idx = '0;
   logic [SW-1:0]    sel = '0;
   logic [1:0]       mode = '0;
   logic             commit = 1'b0;
   logic [N_OUT-1:0] vout;
   logic             pend;
   logic             err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   int               sh_sel [N_OUT];
   int               sh_mode[N_OUT];
   int               ac_sel [N_OUT];
   int               ac_mode[N_OUT];
   logic [N_IN-1:0]  m_cur, m_prev;
   logic             m_pend, m_err;
   logic [N_OUT-1:0] m_vec;

   crossbar_shadow #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .vector_i     (vin),
      .cfg_we_i     (we),
      .cfg_idx_i    (idx),
      .cfg_sel_i    (sel),
      .cfg_mode_i   (mode),
      .cfg_commit_i (commit),
      .vector_o     (vout),
      .cfg_pending_o(pend),
      .cfg_err_o    (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic model_clear();
      for (int x = 0; x < N_OUT; x++) begin
         sh_sel[x] = 0; sh_mode[x] = 0;
         ac_sel[x] = 0; ac_mode[x] = 0;
      end
      m_cur = '0; m_prev = '0;
      m_pend = 1'b0; m_err = 1'b0;
      m_vec = '0;
   endtask

   // event seen by a counter given its mode and the source's
   // value in the newest and previous sampled cycles
   function automatic logic rule(int md, logic now, logic old);
      case (md)
         1: return now;
         2: return now && !old;
         3: return !now && old;
         default: return 1'b0;
      endcase
   endfunction

   // advance one clock edge; model follows the edge, then settle
   task automatic step();
      logic [N_OUT-1:0] nv;
      bit ok;
      @(posedge clk);
      cyc++;
      if (rst) begin
         model_clear();
      end else begin
         for (int x = 0; x < N_OUT; x++)
            nv[x] = rule(ac_mode[x], m_cur[ac_sel[x]],
                         m_prev[ac_sel[x]]);
         m_prev = m_cur;
         m_cur  = vin;
         ok = we && (int'(idx) < N_OUT) && (int'(sel) < N_IN);
         m_err = we && !ok;
         if (ok) begin
            sh_sel[idx]  = int'(sel);
            sh_mode[idx] = int'(mode);
         end
         if (commit) begin
            ac_sel  = sh_sel;
            ac_mode = sh_mode;
            m_pend  = 1'b0;
         end else if (ok) begin
            m_pend = 1'b1;
         end
         m_vec = nv;
      end
      #1;
   endtask

   task automatic drive_cfg(bit w, int i, int s, int m, bit c);
      we = w;
      idx = IW'(i);
      sel = SW'(s);
      mode = 2'(m);
      commit = c;
   endtask

   task automatic test_reset();
      drive_cfg(1, 3, 5, 1, 1);
      vin = '1;
      step(); step();
      checks++;
      if (vout !== '0 || pend !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got v=%h p=%b e=%b req 0/0/0",
                  vout, pend, err);
      end
      drive_cfg(0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++;
         if (vout !== '0 || pend !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d got v=%h p=%b req 0",
                     cyc, vout, pend);
         end
      end
   endtask

   task automatic test_level();
      int t;
      vin = '0;
      drive_cfg(1, 3, 5, 1, 0);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      checks++;
      if (pend !== 1'b1 || vout[3] !== 1'b0) begin
         errors++;
         $display("FAIL level_staged got p=%b v3=%b req 1/0",
                  pend, vout[3]);
      end
      drive_cfg(0, 0, 0, 0, 1);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      checks++;
      if (pend !== 1'b0) begin
         errors++;
         $display("FAIL level_commit_pend got %b req 0", pend);
      end
      step(); step();
      t = cyc;
      vin[5] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (vout[3] !== (cyc >= t + 2) || vout !== m_vec) begin
            errors++;
            $display("FAIL level_lat cyc %0d got %h req %h bit3 %b",
                     cyc, vout, m_vec, cyc >= t + 2);
         end
      end
      vin = '0;
      step(); step();
   endtask

   task automatic run_edge(int md, string nm);
      int pulses;
      int at;
      int t;
      vin = '0;
      drive_cfg(1, 0, 7, md, 1);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step();
      pulses = 0;
      at = -1;
      t = -1;
      for (int k = 0; k < 14; k++) begin
         if (k == 1 || k == 6) begin
            vin[7] = (k == 1);
            if ((k == 1) == (md == 2)) t = cyc;
         end
         step();
         if (vout[0]) begin
            pulses++;
            at = cyc;
         end
         checks++;
         if (vout !== m_vec) begin
            errors++;
            $display("FAIL %s_vec cyc %0d got %h req %h",
                     nm, cyc, vout, m_vec);
         end
      end
      checks++;
      if (pulses != 1 || at != t + 2) begin
         errors++;
         $display("FAIL %s_pulse got n=%0d at=%0d req n=1 at=%0d",
                  nm, pulses, at, t + 2);
      end
   endtask

   task automatic test_edge();
      run_edge(2, "rise");
      run_edge(3, "fall");
   endtask

   task automatic test_write_commit();
      int t;
      vin = '0;
      drive_cfg(1, 1, 2, 1, 1);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      checks++;
      if (pend !== 1'b0) begin
         errors++;
         $display("FAIL wc_pend got %b req 0", pend);
      end
      step(); step();
      t = cyc;
      vin[2] = 1'b1;
      step();
      checks++;
      if (vout[1] !== 1'b0) begin
         errors++;
         $display("FAIL wc_early got %b req 0", vout[1]);
      end
      step();
      checks++;
      if (vout[1] !== 1'b1 || cyc != t + 2) begin
         errors++;
         $display("FAIL wc_hit got %b req 1", vout[1]);
      end
      vin = '0;
      step(); step();
   endtask

   task automatic test_reject();
      logic p0;
      drive_cfg(0, 0, 0, 0, 1);
      step();
      for (int r = 0; r < 2; r++) begin
         p0 = pend;
         if (r == 0) drive_cfg(1, 2, 30, 1, 0);
         else drive_cfg(1, N_OUT, 1, 1, 0);
         step();
         drive_cfg(0, 0, 0, 0, 0);
         checks++;
         if (err !== 1'b1 || pend !== p0 || pend !== 1'b0) begin
            errors++;
            $display("FAIL reject%0d got e=%b p=%b req 1/0",
                     r, err, pend);
         end
         step();
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL reject%0d_clear got %b req 0", r, err);
         end
      end
      drive_cfg(0, 0, 0, 0, 1);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      vin = '1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (vout !== m_vec) begin
            errors++;
            $display("FAIL reject_cfg cyc %0d got %h req %h",
                     cyc, vout, m_vec);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N_OUT; i++) begin
         drive_cfg(1, i, $urandom_range(0, N_IN - 1),
                   $urandom_range(0, 3), 0);
         vin = N_IN'($urandom);
         step();
         checks++;
         if (pend !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wr %0d got p=%b e=%b req 1/0",
                     i, pend, err);
         end
      end
      drive_cfg(0, 0, 0, 0, 1);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      for (int k = 0; k < 30; k++) begin
         vin = N_IN'($urandom);
         step();
         checks++;
         if (vout !== m_vec || pend !== m_pend) begin
            errors++;
            $display("FAIL b2b_run cyc %0d got %h/%b req %h/%b",
                     cyc, vout, pend, m_vec, m_pend);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive_cfg($urandom_range(0, 1), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0);
         vin = N_IN'($urandom);
         step();
         checks++;
         if (vout !== m_vec || pend !== m_pend || err !== m_err) begin
            errors++;
            $display("FAIL rand cyc %0d got %h/%b/%b req %h/%b/%b",
                     cyc, vout, pend, err, m_vec, m_pend, m_err);
         end
      end
      drive_cfg(0, 0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      vin = '1;
      drive_cfg(1, 0, 0, 1, 1);
      step();
      drive_cfg(1, 4, 9, 2, 0);
      step();
      drive_cfg(0, 0, 0, 0, 0);
      step(); step();
      checks++;
      if (vout[0] !== 1'b1 || vout !== m_vec) begin
         errors++;
         $display("FAIL arst_pre got %h req %h", vout, m_vec);
      end
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      checks++;
      if (vout !== '0 || pend !== 1'b0) begin
         errors++;
         $display("FAIL arst_now got v=%h p=%b req 0/0", vout, pend);
      end
      drive_cfg(1, 5, 5, 1, 1);
      step(); step();
      drive_cfg(0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (vout !== '0 || pend !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL arst_post cyc %0d got %h/%b/%b req 0",
                     cyc, vout, pend, err);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_level();
      test_edge();
      test_write_commit();
      test_reject();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crossbar_shadow.md
CROSSBAR_SHADOW -- requirements
Module: crossbar_shadow

Interface
REQ-001: Parameter N_IN, default 32, number of SoC event inputs (>=2).
REQ-002: Parameter N_OUT, default 24, number of PMU counter outputs (>=1).
REQ-003: Derived widths: SW = $clog2(N_IN) selector bits; IW = max(1,$clog2(N_OUT)) index bits.
REQ-004: clk_i  in  1  single clock; all state on rising edge.
REQ-005: rst_i  in  1  reset, asynchronous assert, active-high.
REQ-006: vector_i  in  N_IN  raw event inputs, one bit per event.
REQ-007: cfg_we_i  in  1  shadow-config write strobe.
REQ-008: cfg_idx_i  in  IW  output index written.
REQ-009: cfg_sel_i  in  SW  input selected for that output.
REQ-010: cfg_mode_i  in  2  00 off, 01 level, 10 rising edge, 11 falling edge.
REQ-011: cfg_commit_i  in  1  copy all shadow entries into active config.
REQ-012: vector_o  out  N_OUT  registered per-counter events.
REQ-013: cfg_pending_o  out  1  shadow written since last commit.
REQ-014: cfg_err_o  out  1  one-cycle pulse on rejected write.

Function
REQ-015: Two config banks SHALL exist, shadow and active, each N_OUT entries of {sel, mode}.
REQ-016: Write with cfg_we_i=1, cfg_idx_i<N_OUT, cfg_sel_i<N_IN SHALL update shadow[cfg_idx_i] next edge; active untouched.
REQ-017: Write with cfg_idx_i>=N_OUT or cfg_sel_i>=N_IN SHALL be discarded (no state change) and cfg_err_o SHALL be 1 the following cycle only.
REQ-018: cfg_commit_i=1 SHALL copy every shadow entry to active on the same edge, atomically.
REQ-019: Same-cycle valid write and commit: committed image SHALL include the new write (write bypasses into active).
REQ-020: cfg_pending_o SHALL set on any accepted write without commit, clear on commit (commit wins when simultaneous), unaffected by rejected writes.
REQ-021: Stage 1: in_q <= vector_i; in_qq <= in_q every cycle.
REQ-022: Per output x, with s = active[x].sel: level = in_q[s]; rise = in_q[s] & ~in_qq[s]; fall = ~in_q[s] & in_qq[s].
REQ-023: Stage 2: vector_o[x] <= 0 (off), level, rise or fall per active[x].mode.
REQ-024: Latency vector_i -> vector_o SHALL be exactly 2 cycles in all modes; edge output is a 1-cycle pulse per edge.
REQ-025: New active config SHALL affect vector_o from the cycle after commit edge (first output computed with new config one edge later); no glitch cycle combining old sel with new mode.
REQ-026: Multiple outputs MAY select the same input; each behaves independently.
REQ-027: Edge history is per input, so a commit changing sel SHALL NOT generate a spurious edge from the old source.
REQ-028: Consecutive back-to-back writes (one per cycle) SHALL all be accepted; no backpressure exists.

Reset
REQ-029: While rst_i=1 all state SHALL clear asynchronously: shadow and active entries {sel=0, mode=00}, in_q/in_qq=0, vector_o=0, cfg_pending_o=0, cfg_err_o=0.
REQ-030: Writes or commits asserted during reset SHALL be ignored; after deassertion first edge operates normally.
REQ-031: Reset asserted mid-operation SHALL drop vector_o to 0 immediately without waiting for a clock edge.

Verification
REQ-032: After reset, vector_i=all ones -> vector_o=0 indefinitely, cfg_pending_o=0.
REQ-033: Write idx=3, sel=5, mode=01, no commit -> vector_o[3]=0, cfg_pending_o=1; commit, then vector_i[5]=1 at cycle t -> vector_o[3]=1 at t+2, pending=0.
REQ-034: idx=0, sel=7, mode=10 committed; vector_i[7] held high 5 cycles -> vector_o[0] high exactly 1 cycle, 2 cycles after rise; mode=11 -> single pulse 2 cycles after fall.
REQ-035: N_IN=24: write sel=30 -> cfg_err_o pulse 1 cycle, shadow unchanged, pending unchanged; idx=N_OUT likewise.
REQ-036: Same-cycle write idx=1 sel=2 mode=01 plus commit -> active[1] updated, pending=0; vector_i[2]=1 reaches vector_o[1] after 2 cycles.
REQ-037: Assert rst_i asynchronously between edges with vector_o nonzero -> vector_o=0 immediately; config back to off after release.
